// File: rtl/fifo_tg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_tg_pkg                                                          |
// | Shared types and constants for the FIFO loopback traffic gen/checker |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fifo_tg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int          C_ADD_VAL_DEFAULT = 2;
  localparam logic [31:0] C_LFSR_POLY       = 32'h8020_0003;
  localparam int          C_ERR_W           = 16;

endpackage
`default_nettype wire

// File: rtl/fifo_tg_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_tg_lfsr                                                         |
// | Galois LFSR with load/step; a zero load value is replaced by 1       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fifo_tg_lfsr
  import fifo_tg_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(C_LFSR_POLY)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] r_state;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= '0;
    end else if (load) begin
      // All-zero is the lock-up state of an XOR LFSR
      r_state <= (load_val == '0) ? WIDTH'(1) : load_val;
    end else if (step) begin
      r_state <= {1'b0, r_state[WIDTH-1:1]} ^ (r_state[0] ? POLY : '0);
    end
  end

  assign value = r_state;

endmodule
`default_nettype wire

// File: rtl/fifo_traffic_gen_chk.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_traffic_gen_chk                                                 |
// | Writes a word run into the engine FIFO, reads results back, checks   |
// | each against sent+ADD_VAL. Define FIFO_TG_LFSR_EN for LFSR data.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fifo_traffic_gen_chk
  import fifo_tg_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_WORDS   = 16,
  parameter int ADD_VAL     = C_ADD_VAL_DEFAULT,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [DATA_W-1:0]  seed,
  input  logic               tx_full,
  output logic               tx_wr,
  output logic [DATA_W-1:0]  tx_data,
  input  logic               rx_empty,
  output logic               rx_rd,
  input  logic [DATA_W-1:0]  rx_data,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               timeout,
  output logic [C_ERR_W-1:0] err_count
);

  localparam int                CNT_W     = $clog2(NUM_WORDS + 1);
  localparam int                IDLE_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  C_NUM     = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0]  C_LAST    = CNT_W'(NUM_WORDS - 1);
  localparam logic [IDLE_W-1:0] C_TO_LAST = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [DATA_W-1:0] C_ADD     = DATA_W'(ADD_VAL);

  state_t             r_state;
  logic [CNT_W-1:0]   r_sent_cnt, r_rd_cnt, r_chk_cnt;
  logic [IDLE_W-1:0]  r_idle_cnt;
  logic               r_rd_d, r_busy, r_done, r_pass, r_timeout;
  logic [C_ERR_W-1:0] r_err;

  logic               w_in_run, w_start_acc, w_compare, w_mismatch;
  logic [DATA_W-1:0]  w_expected;
  logic [C_ERR_W-1:0] w_err_next;

  // reset_n gates the strobes so a mid-run reset stops FIFO traffic at once
  assign w_in_run    = reset_n && (r_state == ST_RUN);
  assign w_start_acc = (r_state == ST_IDLE) && start;
  assign tx_wr       = w_in_run && (r_sent_cnt < C_NUM) && !tx_full;
  assign rx_rd       = w_in_run && (r_rd_cnt < C_NUM) && !rx_empty;
  assign w_compare   = (r_state == ST_RUN) && r_rd_d;

`ifdef FIFO_TG_LFSR_EN
  logic [DATA_W-1:0] w_tx_val, w_chk_val;

  fifo_tg_lfsr #(.WIDTH(DATA_W)) u_tx_lfsr (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (w_start_acc),
    .load_val (seed),
    .step     (tx_wr),
    .value    (w_tx_val)
  );

  fifo_tg_lfsr #(.WIDTH(DATA_W)) u_chk_lfsr (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (w_start_acc),
    .load_val (seed),
    .step     (w_compare),
    .value    (w_chk_val)
  );

  assign tx_data    = w_tx_val;
  assign w_expected = w_chk_val + C_ADD;
`else
  logic [DATA_W-1:0] r_tx_val, r_chk_val;

  // Both track seed + count, so the adders wrap naturally mod 2^DATA_W
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_tx_val  <= '0;
      r_chk_val <= '0;
    end else if (w_start_acc) begin
      r_tx_val  <= seed;
      r_chk_val <= seed;
    end else begin
      if (tx_wr)     r_tx_val  <= r_tx_val + 1'b1;
      if (w_compare) r_chk_val <= r_chk_val + 1'b1;
    end
  end

  assign tx_data    = r_tx_val;
  assign w_expected = r_chk_val + C_ADD;
`endif

  assign w_mismatch = w_compare && (rx_data != w_expected);
  assign w_err_next = (w_mismatch && (r_err != '1)) ? r_err + 1'b1 : r_err;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_sent_cnt <= '0;
      r_rd_cnt   <= '0;
      r_chk_cnt  <= '0;
      r_idle_cnt <= '0;
      r_rd_d     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_timeout  <= 1'b0;
      r_err      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state    <= ST_RUN;
            r_busy     <= 1'b1;
            r_sent_cnt <= '0;
            r_rd_cnt   <= '0;
            r_chk_cnt  <= '0;
            r_idle_cnt <= '0;
            r_rd_d     <= 1'b0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
            r_err      <= '0;
          end
        end
        ST_RUN: begin
          if (tx_wr) r_sent_cnt <= r_sent_cnt + 1'b1;
          if (rx_rd) r_rd_cnt   <= r_rd_cnt + 1'b1;
          r_rd_d     <= rx_rd;
          r_idle_cnt <= rx_rd ? '0 : r_idle_cnt + 1'b1;
          if (w_compare) begin
            r_err     <= w_err_next;
            r_chk_cnt <= r_chk_cnt + 1'b1;
          end
          // Completion wins over a coincident timeout
          if (w_compare && (r_chk_cnt == C_LAST)) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end else if (!rx_rd && (r_idle_cnt == C_TO_LAST)) begin
            r_state   <= ST_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_rd_d  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign timeout   = r_timeout;
  assign err_count = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fifo_traffic_gen_chk.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fifo_traffic_gen_chk                                              |
// | Directed bench: FIFO + add-2 engine model around the generator       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fifo_traffic_gen_chk;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] seed = '0;
  logic        tx_full = 1'b0;
  logic        tx_wr;
  logic [31:0] tx_data;
  logic        rx_empty = 1'b1;
  logic        rx_rd;
  logic [31:0] rx_data = '0;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;

  logic        engine_en = 1'b1;
  logic        corrupt_en = 1'b0;
  logic        flush = 1'b0;

  logic [31:0] in_q[$], out_q[$], sent_log[$], rx_log[$];
  logic [31:0] m_word;
  int          eng_idx = 0;
  int          wr_while_full = 0;

  int tests = 0;
  int fails = 0;

  fifo_traffic_gen_chk #(
    .DATA_W(32), .NUM_WORDS(16), .ADD_VAL(2), .TIMEOUT_CYC(64)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .seed      (seed),
    .tx_full   (tx_full),
    .tx_wr     (tx_wr),
    .tx_data   (tx_data),
    .rx_empty  (rx_empty),
    .rx_rd     (rx_rd),
    .rx_data   (rx_data),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  // Input FIFO -> 1-cycle add engine -> output FIFO with registered read data
  always @(posedge clock) begin
    if (flush) begin
      in_q.delete();
      out_q.delete();
      sent_log.delete();
      rx_log.delete();
      eng_idx       = 0;
      wr_while_full = 0;
    end else begin
      if (rx_rd && out_q.size() > 0) begin
        m_word = out_q.pop_front();
        rx_data <= m_word;
        rx_log.push_back(m_word);
      end
      if (engine_en && in_q.size() > 0) begin
        m_word = in_q.pop_front();
        out_q.push_back(m_word + ((corrupt_en && eng_idx == 3) ? 32'd3 : 32'd2));
        eng_idx = eng_idx + 1;
      end
      if (tx_wr) begin
        if (tx_full) wr_while_full = wr_while_full + 1;
        in_q.push_back(tx_data);
        sent_log.push_back(tx_data);
      end
    end
    rx_empty <= (out_q.size() == 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic flush_model();
    @(negedge clock) flush = 1'b1;
    @(negedge clock) flush = 1'b0;
  endtask

  task automatic run_start(input logic [31:0] s);
    flush_model();
    @(negedge clock);
    seed  = s;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_on_start", {31'd0, busy}, 32'd1);
    check("tx_data_seed", tx_data, s);
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 500) begin
      @(negedge clock);
      cycles++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic check_pulse_end();
    @(negedge clock);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int seen;

    // Reset values
    repeat (3) @(negedge clock);
    check("rst_tx_wr", {31'd0, tx_wr}, 32'd0);
    check("rst_tx_data", tx_data, 32'd0);
    check("rst_rx_rd", {31'd0, rx_rd}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_err", {16'd0, err_count}, 32'd0);
    reset_n = 1'b1;

    // Basic run from seed 0x10
    run_start(32'h10);
    wait_done(cyc);
    check("t1_pass", {31'd0, pass}, 32'd1);
    check("t1_err", {16'd0, err_count}, 32'd0);
    check("t1_timeout", {31'd0, timeout}, 32'd0);
    check("t1_nsent", sent_log.size(), 32'd16);
    check("t1_nrx", rx_log.size(), 32'd16);
    for (int i = 0; i < 16; i++) check("t1_tx", sent_log[i], 32'h10 + i);
    check("t1_rx0", rx_log[0], 32'h12);
    check("t1_rx15", rx_log[15], 32'h21);
    check_pulse_end();

    // Wrap-around
    run_start(32'hFFFF_FFFE);
    wait_done(cyc);
    check("t2_pass", {31'd0, pass}, 32'd1);
    check("t2_tx0", sent_log[0], 32'hFFFF_FFFE);
    check("t2_tx1", sent_log[1], 32'hFFFF_FFFF);
    check("t2_tx2", sent_log[2], 32'h0000_0000);
    check("t2_tx3", sent_log[3], 32'h0000_0001);
    check("t2_rx0", rx_log[0], 32'h0000_0000);
    check("t2_rx1", rx_log[1], 32'h0000_0001);
    check("t2_rx2", rx_log[2], 32'h0000_0002);
    check("t2_rx3", rx_log[3], 32'h0000_0003);

    // Back-pressure stall of 10 cycles
    run_start(32'h100);
    repeat (3) @(negedge clock);
    tx_full = 1'b1;
    #1 check("t3_drop_same_cycle", {31'd0, tx_wr}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("t3_stall_wr", {31'd0, tx_wr}, 32'd0);
    end
    tx_full = 1'b0;
    wait_done(cyc);
    check("t3_pass", {31'd0, pass}, 32'd1);
    check("t3_wr_full", wr_while_full, 32'd0);
    check("t3_nsent", sent_log.size(), 32'd16);
    for (int i = 0; i < 16; i++) check("t3_tx", sent_log[i], 32'h100 + i);

    // Corrupted word
    corrupt_en = 1'b1;
    run_start(32'h20);
    wait_done(cyc);
    check("t4_err", {16'd0, err_count}, 32'd1);
    check("t4_pass", {31'd0, pass}, 32'd0);
    check("t4_timeout", {31'd0, timeout}, 32'd0);
    corrupt_en = 1'b0;
    check_pulse_end();
    check("t4_err_hold", {16'd0, err_count}, 32'd1);

    // Engine never returns: timeout after 64 idle cycles
    engine_en = 1'b0;
    run_start(32'h0);
    wait_done(cyc);
    check("t5_cycles", cyc, 32'd64);
    check("t5_timeout", {31'd0, timeout}, 32'd1);
    check("t5_pass", {31'd0, pass}, 32'd0);
    check("t5_err", {16'd0, err_count}, 32'd0);
    check("t5_nrx", rx_log.size(), 32'd0);
    check_pulse_end();
    check("t5_no_wr", {31'd0, tx_wr}, 32'd0);
    check("t5_timeout_hold", {31'd0, timeout}, 32'd1);
    engine_en = 1'b1;

    // Reset mid-run
    run_start(32'h40);
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    #1 check("t6_wr_gated", {31'd0, tx_wr}, 32'd0);
    @(negedge clock);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_tx_data", tx_data, 32'd0);
    check("t6_rx_rd", {31'd0, rx_rd}, 32'd0);
    check("t6_err", {16'd0, err_count}, 32'd0);
    check("t6_timeout", {31'd0, timeout}, 32'd0);
    seen = 0;
    @(negedge clock) reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) seen++;
      @(negedge clock);
    end
    check("t6_no_done", seen, 32'd0);

    // New run passes; a start pulsed while busy is ignored
    run_start(32'h50);
    repeat (2) @(negedge clock);
    seed  = 32'h999;
    start = 1'b1;
    @(negedge clock) start = 1'b0;
    wait_done(cyc);
    check("t7_pass", {31'd0, pass}, 32'd1);
    check("t7_nsent", sent_log.size(), 32'd16);
    check("t7_tx0", sent_log[0], 32'h50);
    check("t7_tx15", sent_log[15], 32'h5F);
    check_pulse_end();
    @(negedge clock);
    check("t7_stays_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_traffic_gen_chk.md
# fifo_traffic_gen_chk

Traffic generator and checker for the FIFO loopback path in the CL FIFO design. It writes a run of words into the FIFO feeding the FIFO processing engine, then reads the processed words back from that engine's output FIFO. Each returned word is checked against the sent value plus a fixed increment, and the block reports pass/fail, the error count and timeout.

## Interface
- DATA_W, 32, data width of both FIFO paths
- NUM_WORDS, 16, words sent and expected back per run (≥1)
- ADD_VAL, 2, increment the processing engine applies to each word
- TIMEOUT_CYC, 1024, max cycles without a returned word before the run aborts
- clock  in  1  system clock
- reset_n  in  1  reset; synchronous, active-low
- start  in  1  single-cycle run request; honoured only in IDLE
- seed  in  DATA_W  first data word; sampled when start is accepted
- tx_full  in  1  full flag of the input FIFO
- tx_wr  out  1  input FIFO write strobe
- tx_data  out  DATA_W  input FIFO write data
- rx_empty  in  1  empty flag of the output FIFO
- rx_rd  out  1  output FIFO read strobe
- rx_data  in  DATA_W  output FIFO read data, valid the cycle after rx_rd
- busy  out  1  high while a run is in progress
- done  out  1  one-cycle pulse when a run ends
- pass  out  1  last run: all words returned, zero mismatches
- timeout  out  1  last run aborted by the timeout
- err_count  out  16  mismatches in the last run; saturates at 16'hFFFF

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE→RUN when start=1. On entry, latch seed and clear the counters, err_count, pass and timeout. While busy, start is ignored.
- Sender in RUN:
  - The write request is high while sent_cnt < NUM_WORDS.
  - tx_wr = request & !tx_full (combinational), so the block never writes into a full FIFO.
  - tx_data = seed + sent_cnt, mod 2^DATA_W. tx_data holds its value until the write is taken.
- Reader in RUN:
  - The read request is high while rd_cnt < NUM_WORDS.
  - rx_rd = request & !rx_empty (combinational). Back-to-back reads are allowed.
- Checker:
  - One cycle after each rx_rd, compare rx_data with seed + chk_cnt + ADD_VAL, mod 2^DATA_W.
  - On a mismatch, increment err_count (saturating). Then increment chk_cnt.
- Sender and reader run concurrently. The sender does not wait for returns.
- RUN→DONE when chk_cnt == NUM_WORDS. pass is set to (err_count==0, including the final compare).
- Timeout:
  - The idle counter clears on every rx_rd and increments otherwise.
  - When it reaches TIMEOUT_CYC: RUN→DONE with timeout=1 and pass=0.
  - Words still in flight are abandoned. No further tx_wr or rx_rd is issued.
- DONE lasts one cycle: done=1 and busy=0. DONE→IDLE. pass, timeout and err_count hold until the next accepted start.

## Timing
- Reset values: tx_wr=0, tx_data=0, rx_rd=0, busy=0, done=0, pass=0, timeout=0, err_count=0, state IDLE, all counters 0.
- Reset mid-run aborts immediately: outputs go to reset values, no done pulse, and FIFO contents are left as they are.
- start sampled at edge t → busy=1 from cycle t+1. The first tx_wr can be high in cycle t+1 if tx_full=0.
- One word per cycle in each direction at best. With a 1-cycle engine, the minimum run length is about NUM_WORDS+4 cycles.
- If tx_full rises, tx_wr drops in the same cycle. If rx_empty rises, rx_rd drops in the same cycle.
- Compare happens one cycle after the read. done is asserted the cycle after the last compare.
- Wrap-around: seed=32'hFFFFFFFF sends FFFFFFFF then 00000000. The expected returns are 00000001 then 00000002.

## Configuration
- FIFO_TG_LFSR_EN defined:
  - tx_data comes from a 32-bit Galois LFSR (polynomial 0x80200003) seeded with seed. A seed of 0 is replaced by 1.
  - The checker runs an identical LFSR, advanced once per compare, and adds ADD_VAL to its output.
- FIFO_TG_LFSR_EN undefined: incrementing pattern as above. No LFSR logic is built.

## Structure
- Package fifo_tg_pkg holds the state enum, the default ADD_VAL, the LFSR polynomial constant and the err_count width.
- Sub-module fifo_tg_lfsr implements the LFSR (load, step, value). It is instantiated twice, for the sender and the checker, only under FIFO_TG_LFSR_EN.

## Test plan
- Model engine (add 2, 1-cycle), seed=0x10, NUM_WORDS=16 → tx_data 0x10..0x1F; 16 compares; done pulse; pass=1; err_count=0; timeout=0.
- Seed=0xFFFFFFFE, NUM_WORDS=4 → sends FFFFFFFE, FFFFFFFF, 0, 1; expects 0, 1, 2, 3; pass=1.
- Hold tx_full=1 for 10 cycles mid-run → no tx_wr during the stall, no lost or duplicated words, pass=1.
- Engine corrupts word 3 (+3 instead of +2) → err_count=1, pass=0, run still completes with done.
- Engine never returns data, TIMEOUT_CYC=64 → done 64 cycles after the last rx activity (run start), timeout=1, pass=0.
- Assert reset_n=0 mid-run, then start again → all outputs at reset values with no done pulse; the new run passes. start pulsed while busy is ignored.
